// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one requester of the data-memory arbiter.
// The requester drives the master side; the arbiter sits on the slave side.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [2:0]  acc_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, acc_type, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, acc_type, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and fixed IDLE/ACCESS/RESP sequencer in front
// of the single-port data memory; illegal accesses never reach the memory.
module dmem_arbiter #(
    parameter int MEM_WORDS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        m0,
    dmem_arbiter_if.slave        m1,
    output logic                 d_wr_en,
    output logic [2:0]           store_type,
    output logic [2:0]           load_type,
    output logic [31:0]          dAddr,
    output logic [31:0]          dWdata,
    input  logic [31:0]          dRdata
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        accept;
    logic        winner;
    logic        last_grant_q;
    logic        owner_q;
    logic        err_q;
    logic        we_q;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  gnt_q;
    logic [1:0]  rvalid_q;
    logic [1:0]  err_out_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        sel_we;
    logic [2:0]  sel_type;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        mem_live;

    function automatic logic access_err(input logic we, input logic [2:0] t,
                                        input logic [31:0] a);
        logic e;
        e = 1'b0;
        if ((t == 3'b001 || t == 3'b101) && a[0])
            e = 1'b1;
        if (t == 3'b010 && a[1:0] != 2'b00)
            e = 1'b1;
        if (!we && (t == 3'b011 || t == 3'b110 || t == 3'b111))
            e = 1'b1;
        if (we && !(t == 3'b000 || t == 3'b001 || t == 3'b010))
            e = 1'b1;
        if (a[31:2] >= WORD_LIMIT)
            e = 1'b1;
        return e;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Requests are only sampled in IDLE; on contention the port that did
    // not win last time goes first.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        winner  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    accept  = 1'b1;
                    winner  = (m0.req && m1.req) ? ~last_grant_q : m1.req;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sel_we    = winner ? m1.we       : m0.we;
    assign sel_type  = winner ? m1.acc_type : m0.acc_type;
    assign sel_addr  = winner ? m1.addr     : m0.addr;
    assign sel_wdata = winner ? m1.wdata    : m0.wdata;
    assign sel_err   = access_err(sel_we, sel_type, sel_addr);

    // IDLE -> ACCESS: latch the winner; ACCESS -> RESP: capture the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            type_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            err_out_q    <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            err_out_q <= 2'b00;
            if (accept) begin
                last_grant_q <= winner;
                owner_q      <= winner;
                err_q        <= sel_err;
                we_q         <= sel_we;
                type_q       <= sel_type;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                gnt_q        <= winner ? 2'b10 : 2'b01;
            end
            if (state_q == ACCESS) begin
                rvalid_q  <= owner_q ? 2'b10 : 2'b01;
                err_out_q <= err_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
                if (owner_q)
                    rdata1_q <= (!err_q && !we_q) ? dRdata : '0;
                else
                    rdata0_q <= (!err_q && !we_q) ? dRdata : '0;
            end
        end
    end

    // The memory only sees a legal access, and only for the ACCESS cycle.
    assign mem_live   = (state_q == ACCESS) && !err_q;
    assign d_wr_en    = mem_live && we_q;
    assign dAddr      = mem_live ? addr_q  : '0;
    assign dWdata     = mem_live ? wdata_q : '0;
    assign store_type = mem_live ? type_q  : 3'b000;
    assign load_type  = mem_live ? type_q  : 3'b000;

    assign m0.gnt    = gnt_q[0];
    assign m1.gnt    = gnt_q[1];
    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.err    = err_out_q[0];
    assign m1.err    = err_out_q[1];
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-port data memory.
- Port m0 is the CPU load/store unit; port m1 is the program loader/debug port.
- Serialises requests with a fixed 3-cycle transaction (IDLE, ACCESS, RESP), using round-robin fairness.
- Rejects misaligned, illegal-type and out-of-range accesses before they reach memory.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; word index addr[31:2] must be < MEM_WORDS.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mX_req  in  1  request valid (X = 0, 1); held until mX_gnt is observed
- mX_we  in  1  1 = store, 0 = load
- mX_type  in  3  funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mX_addr  in  32  byte address
- mX_wdata  in  32  store data (LSB-aligned)
- mX_gnt  out  1  one-cycle pulse: request accepted
- mX_rvalid  out  1  one-cycle pulse: transaction complete
- mX_rdata  out  32  load result, valid while mX_rvalid is high
- mX_err  out  1  qualifies mX_rvalid: access rejected
- d_wr_en  out  1  memory write enable
- store_type  out  3  memory store type
- load_type  out  3  memory load type
- dAddr  out  32  memory address
- dWdata  out  32  memory write data
- dRdata  in  32  memory combinational read data

Behaviour:
- Reset (asynchronous, rst_n = 0): state = IDLE, last_grant = 1, latched request registers = 0.
  - All outputs are 0: gnt, rvalid, err, rdata, d_wr_en, store_type, load_type, dAddr, dWdata.
- FSM state IDLE:
  - At the rising edge, if any mX_req = 1, latch the winner's we/type/addr/wdata plus an owner bit and an err flag, then go to ACCESS.
  - If no request, stay in IDLE.
- Arbitration: if a single requester is active, it wins. If both are active, the winner is the port that is not last_grant. last_grant updates on acceptance.
- FSM state ACCESS (1 cycle):
  - mX_gnt = 1 for the owner, registered and glitch-free.
  - If err = 0: dAddr = latched addr, dWdata = latched wdata, store_type = load_type = latched type, d_wr_en = latched we.
  - If err = 1: d_wr_en = 0 and dAddr = 0.
  - At the closing edge:
    - A store commits in memory.
    - A load captures dRdata into the owner's rdata register (err = 0 only).
    - The state advances to RESP.
- FSM state RESP (1 cycle):
  - mX_rvalid = 1 for the owner, for both loads and stores.
  - mX_err = latched err.
  - mX_rdata = captured data for an error-free load, otherwise 0.
  - Next state is IDLE.
- Memory signals in IDLE and RESP: d_wr_en = 0; dAddr, dWdata, store_type and load_type = 0.
- Timing:
  - Request sampled at edge E0; gnt is high during cycle E0–E1; rvalid is high during cycle E1–E2.
  - Throughput is 1 transaction per 3 cycles.
- Requester protocol: the requester must deassert mX_req while gnt is high (req is not sampled in ACCESS or RESP). A req still high at the next IDLE edge is treated as a new transaction.
- Error conditions (err = 1), evaluated combinationally from the request at acceptance:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 00.
  - Load type in {011, 110, 111}.
  - Store type not in {000, 001, 010}.
  - addr[31:2] >= MEM_WORDS.
- The non-owner port sees gnt, rvalid and err = 0 throughout. Its rdata holds its last value (0 after reset).
- Reset mid-transaction: an asynchronous assertion during ACCESS forces d_wr_en = 0 immediately, so no write occurs. A pending rvalid is lost, and the requester must reissue after reset.

Test Plan:
1. Reset, m0 store W, addr 0x10, wdata 0xDEADBEEF -> m0_gnt in cycle 1 with d_wr_en = 1, dAddr = 0x10, store_type = 010; m0_rvalid = 1, m0_err = 0 in cycle 2. Then m0 load W, addr 0x10 -> m0_rdata = 0xDEADBEEF.
2. m1 store B, addr 0x13, data 0x80; then m1 load B, addr 0x13 -> rdata = 0xFFFFFF80. Load BU, addr 0x13 -> rdata = 0x00000080.
3. m0 and m1 both request continuously, each dropping req while its gnt is high -> grants alternate m0, m1, m0, m1 (m0 first after reset). Neither port waits longer than one foreign transaction.
4. m0 load H, addr 0x21; m0 load W, addr 0x06; m0 store type 100; m0 load W, addr 0x100 (with MEM_WORDS = 64) -> each returns rvalid = 1, err = 1, rdata = 0, with d_wr_en never asserted.
5. m0 store W, addr 0x04, value 0x11111111, with rst_n pulled low during ACCESS -> all outputs 0 immediately; after reset, a load W from 0x04 does not return 0x11111111 (memory is pre-initialised to 0 in the bench).
6. No requests for 10 cycles -> state stays IDLE and every output stays 0.
